// File: rtl/jtag_pkg.sv
`default_nettype none
// jtag_pkg: IEEE 1149.1 TAP state encoding and next-state function.
// Revision: 1.0

package jtag_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    case (s)
      TLR:      n = tms ? TLR    : RTI;
      RTI:      n = tms ? SEL_DR : RTI;
      SEL_DR:   n = tms ? SEL_IR : CAP_DR;
      CAP_DR:   n = tms ? EX1_DR : SH_DR;
      SH_DR:    n = tms ? EX1_DR : SH_DR;
      EX1_DR:   n = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: n = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   n = tms ? UPD_DR : SH_DR;
      UPD_DR:   n = tms ? SEL_DR : RTI;
      SEL_IR:   n = tms ? TLR    : CAP_IR;
      CAP_IR:   n = tms ? EX1_IR : SH_IR;
      SH_IR:    n = tms ? EX1_IR : SH_IR;
      EX1_IR:   n = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: n = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   n = tms ? UPD_IR : SH_IR;
      UPD_IR:   n = tms ? SEL_DR : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tap_controller_new.sv
`default_nettype none
// tap_controller_new: 1149.1 TAP FSM with IR/DR shift, capture, update and gated-clock controls.
// Revision: 1.0

module tap_controller_new
  import jtag_pkg::*;
(
  input  logic tck,
  input  logic trst,
  input  logic tms,
  output logic reset,
  output logic tdo_en,
  output logic shiftIR,
  output logic captureIR,
  output logic clockIR,
  output logic updateIR,
  output logic shiftDR,
  output logic captureDR,
  output logic clockDR,
  output logic updateDR,
  output logic updateDRstate,
  output logic select
);

  tap_state_t r_state;
  logic       r_reset;
  logic       r_select;
  logic       r_shift_ir;
  logic       r_shift_dr;
  logic       r_tdo_en;
  logic       r_en_ir;
  logic       r_en_dr;
  logic       w_ir_branch;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) r_state <= TLR;
    else       r_state <= tap_next(r_state, tms);
  end

  always_comb begin
    w_ir_branch = 1'b0;
    case (r_state)
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR: w_ir_branch = 1'b1;
      default:                                                 w_ir_branch = 1'b0;
    endcase
  end

  // Falling-edge copies keep the enables stable across the whole high phase of tck.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      r_reset    <= 1'b1;
      r_select   <= 1'b0;
      r_shift_ir <= 1'b0;
      r_shift_dr <= 1'b0;
      r_tdo_en   <= 1'b0;
      r_en_ir    <= 1'b0;
      r_en_dr    <= 1'b0;
    end else begin
      r_reset    <= (r_state == TLR);
      r_select   <= w_ir_branch;
      r_shift_ir <= (r_state == SH_IR);
      r_shift_dr <= (r_state == SH_DR);
      r_tdo_en   <= (r_state == SH_IR) || (r_state == SH_DR);
      r_en_ir    <= (r_state == CAP_IR) || (r_state == SH_IR);
      r_en_dr    <= (r_state == CAP_DR) || (r_state == SH_DR);
    end
  end

  assign reset         = r_reset;
  assign select        = r_select;
  assign shiftIR       = r_shift_ir;
  assign shiftDR       = r_shift_dr;
  assign tdo_en        = r_tdo_en;
  assign captureIR     = (r_state == CAP_IR);
  assign captureDR     = (r_state == CAP_DR);
  assign clockIR       = tck & r_en_ir;
  assign clockDR       = tck & r_en_dr;
  assign updateIR      = ~tck & (r_state == UPD_IR);
  assign updateDR      = ~tck & (r_state == UPD_DR);
  assign updateDRstate = (r_state == UPD_DR);

endmodule

`default_nettype wire

// File: tb/tb_tap_controller_new.sv
`default_nettype none
`timescale 1ns/100ps
// tb_tap_controller_new: randomized and directed TMS sequences against a branch/phase TAP model.
// Revision: 1.0

module tb_tap_controller_new;

  logic tck = 1'b1;
  logic trst = 1'b1;
  logic tms = 1'b1;
  logic reset, tdo_en, shiftIR, captureIR, clockIR, updateIR;
  logic shiftDR, captureDR, clockDR, updateDR, updateDRstate, select;
  logic [11:0] w_outs;

  int n_vec = 0;
  int n_err = 0;

  tap_controller_new dut (
    .tck(tck), .trst(trst), .tms(tms), .reset(reset), .tdo_en(tdo_en),
    .shiftIR(shiftIR), .captureIR(captureIR), .clockIR(clockIR), .updateIR(updateIR),
    .shiftDR(shiftDR), .captureDR(captureDR), .clockDR(clockDR), .updateDR(updateDR),
    .updateDRstate(updateDRstate), .select(select)
  );

  always #5 tck = ~tck;

  assign w_outs = {reset, tdo_en, shiftIR, captureIR, clockIR, updateIR,
                   shiftDR, captureDR, clockDR, updateDR, updateDRstate, select};

  // Model: a phase within a branch (0 = DR, 1 = IR) instead of a 16-state code.
  localparam int P_TLR = 0, P_RTI = 1, P_SEL = 2, P_CAP = 3, P_SH = 4,
                 P_EX1 = 5, P_PAUSE = 6, P_EX2 = 7, P_UPD = 8;
  int m_ph = P_TLR, m_br = 0;
  logic [11:0] exp_hi, act_hi, exp_lo, act_lo;

  task automatic model_advance(input bit t);
    case (m_ph)
      P_TLR:   m_ph = t ? P_TLR : P_RTI;
      P_RTI:   begin m_ph = t ? P_SEL : P_RTI; m_br = 0; end
      P_SEL:   if (!t) m_ph = P_CAP;
               else if (m_br == 0) m_br = 1;
               else begin m_ph = P_TLR; m_br = 0; end
      P_CAP, P_SH: m_ph = t ? P_EX1 : P_SH;
      P_EX1:   m_ph = t ? P_UPD : P_PAUSE;
      P_PAUSE: m_ph = t ? P_EX2 : P_PAUSE;
      P_EX2:   m_ph = t ? P_UPD : P_SH;
      default: begin m_ph = t ? P_SEL : P_RTI; m_br = 0; end
    endcase
  endtask

  // Registered outputs follow the state seen at the last falling edge (rp/rb).
  function automatic logic [11:0] exp_vec(input int ph, input int br, input int rp,
                                          input int rb, input bit hi);
    logic ir_r, dr_r, ir_c, dr_c;
    ir_r = (rb == 1); dr_r = (rb == 0); ir_c = (br == 1); dr_c = (br == 0);
    return {rp == P_TLR, rp == P_SH, rp == P_SH && ir_r, ph == P_CAP && ir_c,
            hi && ir_r && (rp == P_CAP || rp == P_SH), !hi && ph == P_UPD && ir_c,
            rp == P_SH && dr_r, ph == P_CAP && dr_c,
            hi && dr_r && (rp == P_CAP || rp == P_SH), !hi && ph == P_UPD && dr_c,
            ph == P_UPD && dr_c, rp >= P_SEL && ir_r};
  endfunction

  task automatic tick(input bit t);
    int pp, pb;
    tms = t;
    @(posedge tck); #1;
    pp = m_ph; pb = m_br;
    model_advance(t);
    exp_hi = exp_vec(m_ph, m_br, pp, pb, 1'b1);
    act_hi = w_outs;
    @(negedge tck); #1;
    exp_lo = exp_vec(m_ph, m_br, m_ph, m_br, 1'b0);
    act_lo = w_outs;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    #2 trst = 1'b0;
    #0.5;
    m_ph = P_TLR; m_br = 0;
    e = exp_vec(P_TLR, 0, P_TLR, 0, 1'b1);
    n_vec++;
    if (w_outs !== e) begin
      n_err++;
      $display("FAIL reset_async: got %b expected %b", w_outs, e);
    end
    #0.5 trst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      n_vec += 2;
      if (act_hi !== exp_hi) begin n_err++; $display("FAIL reset_hold_hi[%0d]: got %b expected %b", i, act_hi, exp_hi); end
      if (act_lo !== exp_lo) begin n_err++; $display("FAIL reset_hold_lo[%0d]: got %b expected %b", i, act_lo, exp_lo); end
    end
  endtask

  task automatic test_dr_shift();
    bit seq [8] = '{0, 1, 0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 8; i++) begin
      tick(seq[i]);
      n_vec += 2;
      if (act_hi !== exp_hi) begin n_err++; $display("FAIL dr_shift_hi[%0d]: got %b expected %b", i, act_hi, exp_hi); end
      if (act_lo !== exp_lo) begin n_err++; $display("FAIL dr_shift_lo[%0d]: got %b expected %b", i, act_lo, exp_lo); end
    end
    tick(1'b0);
    n_vec++;
    if (act_lo !== exp_lo) begin n_err++; $display("FAIL dr_to_rti: got %b expected %b", act_lo, exp_lo); end
  endtask

  task automatic test_ir_path();
    bit seq [10] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
    for (int i = 0; i < 10; i++) begin
      tick(seq[i]);
      n_vec += 2;
      if (act_hi !== exp_hi) begin n_err++; $display("FAIL ir_path_hi[%0d]: got %b expected %b", i, act_hi, exp_hi); end
      if (act_lo !== exp_lo) begin n_err++; $display("FAIL ir_path_lo[%0d]: got %b expected %b", i, act_lo, exp_lo); end
    end
  endtask

  task automatic test_pause_loop();
    bit seq [11] = '{1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      tick(seq[i]);
      n_vec += 2;
      if (act_hi !== exp_hi) begin n_err++; $display("FAIL pause_hi[%0d]: got %b expected %b", i, act_hi, exp_hi); end
      if (act_lo !== exp_lo) begin n_err++; $display("FAIL pause_lo[%0d]: got %b expected %b", i, act_lo, exp_lo); end
    end
  endtask

  task automatic test_reset_mid_shift();
    bit seq [10] = '{1, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    logic [11:0] e;
    for (int i = 0; i < 10; i++) tick(seq[i]);
    tms = 1'b0;
    @(posedge tck); #1;
    model_advance(1'b0);
    e = exp_vec(m_ph, m_br, m_ph, m_br, 1'b1);
    n_vec++;
    if (w_outs !== e) begin n_err++; $display("FAIL shift_ir_before_trst: got %b expected %b", w_outs, e); end
    trst = 1'b0;
    #1;
    m_ph = P_TLR; m_br = 0;
    e = exp_vec(P_TLR, 0, P_TLR, 0, 1'b1);
    n_vec++;
    if (w_outs !== e) begin n_err++; $display("FAIL trst_mid_shift: got %b expected %b", w_outs, e); end
    #1 trst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      n_vec += 2;
      if (act_hi !== exp_hi) begin n_err++; $display("FAIL post_trst_hi[%0d]: got %b expected %b", i, act_hi, exp_hi); end
      if (act_lo !== exp_lo) begin n_err++; $display("FAIL post_trst_lo[%0d]: got %b expected %b", i, act_lo, exp_lo); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) == 0);
      n_vec += 2;
      if (act_hi !== exp_hi) begin n_err++; $display("FAIL random_hi[%0d]: got %b expected %b", i, act_hi, exp_hi); end
      if (act_lo !== exp_lo) begin n_err++; $display("FAIL random_lo[%0d]: got %b expected %b", i, act_lo, exp_lo); end
      // Periodically force the five-ones escape and confirm Test-Logic-Reset is reached.
      if (i % 50 == 49) begin
        for (int k = 0; k < 5; k++) tick(1'b1);
        n_vec++;
        if (reset !== 1'b1) begin n_err++; $display("FAIL five_tms[%0d]: reset got %b expected 1", i, reset); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dr_shift();
    test_ir_path();
    test_pause_loop();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
